fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage PC generator and 2-bit branch predictor feeding the IF stage and the IF control logic.
- Holds the PC register and picks the next PC from the control logic's pc_select code.
- Predicts conditional branches at fetch and tracks each prediction into X. Produces br_pred_correct and updates the predictor on resolution.

Parameters:
- RESET_PC, 32'h0000_2000, PC value loaded on reset and on pc_select=0.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 2.
- BHT_IDX_W, 6, log2(BHT_ENTRIES); index is pc[BHT_IDX_W+1:2].

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  freeze PC, X-tracking registers and predictor update.
- pc_select  in  3  0=reset vector, 1=jal, 2=sequential/predicted, 3=redirect (jalr or branch mispredict); 4-7 treated as 2.
- instruction  in  32  IF-stage instruction at pc.
- jal_target  in  32  IF-computed jal target.
- alu_target  in  32  X-stage ALU result, target for jalr and taken branches.
- x_is_branch  in  1  X-stage instruction is a conditional branch (opcode BRANCH).
- br_taken  in  1  X-stage branch comparator outcome.
- pc  out  32  current fetch PC.
- br_pred_taken  out  1  IF-stage prediction, combinational.
- x_pc  out  32  PC of the instruction in X.
- br_pred_correct  out  1  X-stage prediction matched outcome, combinational.
- mispredict_count  out  32  saturating count of resolved mispredictions.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, x_pc=0, x_pred_taken=0, x_valid=0, all BHT counters=2'b01 (weakly not-taken), mispredict_count=0. Reset dominates stall and all other inputs. Reset mid-operation discards any in-flight prediction and performs no BHT update that cycle.
- Prediction:
  - if_is_branch = (instruction[6:2]==OPC_BRANCH_5).
  - br_pred_taken = if_is_branch & bht[pc index][1].
  - b_target = pc + sign-extended B-immediate {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; 32-bit arithmetic, wrap-around permitted.
- Next PC (when !rst & !stall):
  - pc_select=0: RESET_PC.
  - pc_select=1: jal_target.
  - pc_select=3 with x_valid & x_is_branch: br_taken ? alu_target : x_pc+4.
  - pc_select=3 otherwise (jalr): alu_target.
  - pc_select=2: br_pred_taken ? b_target : pc+4.
- X tracking (when !rst & !stall):
  - x_pc<=pc, x_pred_taken<=br_pred_taken, x_valid<=1.
  - Exception: pc_select=3 or 0 flushes the wrong-path fetch: x_valid<=0, x_pred_taken<=0.
- br_pred_correct = !(x_valid & x_is_branch) | (x_pred_taken==br_taken). Combinational, zero latency. It is 1 whenever X holds no valid branch.
- BHT update (when x_valid & x_is_branch & !stall & !rst): counter at x_pc index increments if br_taken, decrements otherwise, saturating at 0 and 3. Same-cycle read and update of the same index: the read returns the pre-update value (no bypass).
- mispredict_count: increments by 1 on each cycle with an update and br_pred_correct=0. Holds at 32'hFFFF_FFFF.
- Stall: pc, x_* registers, BHT and counter all hold; outputs remain combinationally valid.
- Latency: 1 cycle from pc_select to pc. Mispredict penalty is exactly 1 fetched instruction (flushed).

Decomposition:
- Shared package:
  - opcode constants (OPC_BRANCH_5 etc., already shared);
  - pc_select encodings PCSEL_RESET=0, PCSEL_JAL=1, PCSEL_SEQ=2, PCSEL_REDIRECT=3;
  - BHT_INIT=2'b01;
  - RESET_PC default.
- One sub-module: bht_2bit (counter array, 1 combinational read port, 1 synchronous update port, reset init).

Test Plan:
- Reset: rst=1 for 2 cycles, then pc_select=2 with non-branch instructions -> pc=0x2000, then 0x2004, 0x2008; br_pred_correct=1; mispredict_count=0.
- Cold branch at 0x2010, B-imm=+0x40, br_taken=1:
  - br_pred_taken=0; next cycle br_pred_correct=0 and pc_select=3 -> pc=alu_target 0x2050.
  - Counter 01->10; mispredict_count=1.
  - Refetch of 0x2010: br_pred_taken=1, pc goes to 0x2050 directly.
- Predicted taken but not taken:
  - Counter at 2'b11 for 0x2010, br_taken=0 in X -> pc=x_pc+4=0x2014; x_valid cleared for the flushed fetch; counter 11->10.
- Saturation: 4 consecutive taken resolutions at the same index -> counter stays 11. 4 not-taken -> counter reaches 00 and stays there.
- Stall: stall=1 for 3 cycles during a branch resolution -> pc, x_pc and counter unchanged, no count increment; the update occurs on the first unstalled cycle.
- jal/jalr: pc_select=1 with jal_target=0x3000 -> pc=0x3000, x_valid stays 1. pc_select=3 with x_is_branch=0 and alu_target=0x4004 -> pc=0x4004, BHT unchanged.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the fetch stage: opcodes, pc_select codes, BHT init, reset vector.
package fetch_pc_unit_pkg;

  // Opcode field instruction[6:2]
  localparam logic [4:0] OPC_LOAD_5   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM_5  = 5'b00100;
  localparam logic [4:0] OPC_STORE_5  = 5'b01000;
  localparam logic [4:0] OPC_OP_5     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
  localparam logic [4:0] OPC_JALR_5   = 5'b11001;
  localparam logic [4:0] OPC_JAL_5    = 5'b11011;

  // pc_select encodings; 4-7 behave like PCSEL_SEQ
  localparam logic [2:0] PCSEL_RESET    = 3'd0;
  localparam logic [2:0] PCSEL_JAL      = 3'd1;
  localparam logic [2:0] PCSEL_SEQ      = 3'd2;
  localparam logic [2:0] PCSEL_REDIRECT = 3'd3;

  // Weakly not-taken
  localparam logic [1:0] BHT_INIT = 2'b01;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;

  // Sign-extended B-type immediate
  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_bht.sv
// Array of 2-bit saturating branch counters: one combinational read port,
// one synchronous update port. Reads see the pre-update value.
module bht_2bit
  import fetch_pc_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [ENTRIES];

  // Combinational read, no bypass from the update port
  assign rd_ctr = ctr_q[rd_idx];

  // Counter array: reset to weakly not-taken, saturating inc/dec on update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_INIT;
    end else if (upd_en) begin
      if (upd_taken) begin
        if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
      end else begin
        if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register, next-PC selection, branch prediction at IF and
// tracking of that prediction into X for resolution and BHT training.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          BHT_ENTRIES = 64,
  parameter int          BHT_IDX_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_select,
  input  logic [31:0] instruction,
  input  logic [31:0] jal_target,
  input  logic [31:0] alu_target,
  input  logic        x_is_branch,
  input  logic        br_taken,
  output logic [31:0] pc,
  output logic        br_pred_taken,
  output logic [31:0] x_pc,
  output logic        br_pred_correct,
  output logic [31:0] mispredict_count
);

  logic [31:0] pc_next;
  logic [31:0] b_target;
  logic        if_is_branch;
  logic [1:0]  rd_ctr;
  logic        x_pred_taken;
  logic        x_valid;
  logic        x_branch_valid;
  logic        bht_upd;
  logic        flush;

  // Instruction bits outside the opcode and B-immediate fields are not needed here
  logic unused_bits;
  assign unused_bits = ^{instruction[24:12], instruction[1:0], rd_ctr[0]};

  assign if_is_branch    = (instruction[6:2] == OPC_BRANCH_5);
  assign br_pred_taken   = if_is_branch & rd_ctr[1];
  assign b_target        = pc + b_imm(instruction);
  assign x_branch_valid  = x_valid & x_is_branch;
  assign br_pred_correct = !x_branch_valid | (x_pred_taken == br_taken);
  assign bht_upd         = x_branch_valid & !stall & !rst;
  assign flush           = (pc_select == PCSEL_REDIRECT) | (pc_select == PCSEL_RESET);

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_ctr    (rd_ctr),
    .upd_en    (bht_upd),
    .upd_idx   (x_pc[BHT_IDX_W+1:2]),
    .upd_taken (br_taken)
  );

  // Next-PC mux; undefined select codes fall back to sequential/predicted
  always_comb begin
    pc_next = br_pred_taken ? b_target : pc + 32'd4;
    case (pc_select)
      PCSEL_RESET: pc_next = RESET_PC;
      PCSEL_JAL:   pc_next = jal_target;
      PCSEL_REDIRECT: begin
        if (x_branch_valid) pc_next = br_taken ? alu_target : x_pc + 32'd4;
        else                pc_next = alu_target;
      end
      default: ;
    endcase
  end

  // PC and X-stage tracking; redirect/reset squash the wrong-path fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      x_pc         <= '0;
      x_pred_taken <= 1'b0;
      x_valid      <= 1'b0;
    end else if (!stall) begin
      pc           <= pc_next;
      x_pc         <= pc;
      x_pred_taken <= flush ? 1'b0 : br_pred_taken;
      x_valid      <= !flush;
    end
  end

  // Saturating count of resolved mispredictions
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_count <= '0;
    end else if (bht_upd && !br_pred_correct && mispredict_count != 32'hFFFF_FFFF) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, cold/warm branches, mispredict
// flush, counter saturation, stall and jal/jalr redirects.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] BR40  = 32'h0400_0063; // beq, B-imm = +0x40
  localparam logic [31:0] BR_PC = 32'h0000_2010;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_select;
  logic [31:0] instruction;
  logic [31:0] jal_target;
  logic [31:0] alu_target;
  logic        x_is_branch;
  logic        br_taken;
  logic [31:0] pc;
  logic        br_pred_taken;
  logic [31:0] x_pc;
  logic        br_pred_correct;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  logic [1:0]  exp_ctr;
  logic [31:0] exp_mis;

  fetch_pc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .pc_select        (pc_select),
    .instruction      (instruction),
    .jal_target       (jal_target),
    .alu_target       (alu_target),
    .x_is_branch      (x_is_branch),
    .br_taken         (br_taken),
    .pc               (pc),
    .br_pred_taken    (br_pred_taken),
    .x_pc             (x_pc),
    .br_pred_correct  (br_pred_correct),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One branch at BR_PC: jal to it, fetch it predicted, resolve with 'taken'
  task automatic run_branch(input logic taken);
    logic pred;
    x_is_branch = 1'b0; instruction = NOP; pc_select = 3'd1; jal_target = BR_PC;
    tick();
    instruction = BR40; pc_select = 3'd2;
    #1;
    pred = exp_ctr[1];
    chk("rb_pred", {31'b0, br_pred_taken}, {31'b0, pred});
    tick();
    chk("rb_pc_fetch", pc, pred ? 32'h2050 : 32'h2014);
    instruction = NOP; x_is_branch = 1'b1; br_taken = taken; alu_target = 32'h2050;
    pc_select = (pred == taken) ? 3'd2 : 3'd3;
    #1;
    chk("rb_correct", {31'b0, br_pred_correct}, {31'b0, pred == taken});
    tick();
    if (pred != taken) exp_mis = exp_mis + 1;
    if (taken && exp_ctr != 2'b11) exp_ctr = exp_ctr + 1;
    if (!taken && exp_ctr != 2'b00) exp_ctr = exp_ctr - 1;
    chk("rb_ctr", {30'b0, dut.u_bht.ctr_q[4]}, {30'b0, exp_ctr});
    chk("rb_mis", mispredict_count, exp_mis);
    x_is_branch = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_select = 3'd2; instruction = NOP;
    jal_target = '0; alu_target = '0; x_is_branch = 1'b0; br_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h2000);
    chk("rst_xpc", x_pc, 32'h0);
    chk("rst_mis", mispredict_count, 32'h0);
    chk("rst_corr", {31'b0, br_pred_correct}, 32'h1);
    chk("rst_ctr", {30'b0, dut.u_bht.ctr_q[4]}, 32'h1);

    tick(); chk("seq_2004", pc, 32'h2004);
    tick(); chk("seq_2008", pc, 32'h2008);
    chk("seq_xpc", x_pc, 32'h2004);
    chk("seq_corr", {31'b0, br_pred_correct}, 32'h1);
    tick(); tick();
    chk("seq_2010", pc, 32'h2010);

    // Cold branch, resolves taken -> mispredict
    instruction = BR40;
    #1;
    chk("cold_pred", {31'b0, br_pred_taken}, 32'h0);
    tick();
    chk("cold_pc", pc, 32'h2014);
    chk("cold_xpc", x_pc, 32'h2010);
    instruction = NOP; x_is_branch = 1'b1; br_taken = 1'b1; alu_target = 32'h2050;
    pc_select = 3'd3;
    #1;
    chk("cold_corr", {31'b0, br_pred_correct}, 32'h0);
    tick();
    chk("cold_redir", pc, 32'h2050);
    chk("cold_ctr", {30'b0, dut.u_bht.ctr_q[4]}, 32'h2);
    chk("cold_mis", mispredict_count, 32'h1);
    chk("cold_flush", {31'b0, br_pred_correct}, 32'h1);

    // Warm refetch predicted taken, resolves taken
    exp_ctr = 2'b10; exp_mis = 32'd1;
    run_branch(1'b1);
    chk("warm_pc", pc, 32'h2054);

    // Predicted taken, resolves not taken: pc = x_pc+4, flushed slot
    run_branch(1'b0);
    chk("nt_pc", pc, 32'h2014);
    x_is_branch = 1'b1; br_taken = 1'b1; pc_select = 3'd2;
    #1;
    chk("nt_flush", {31'b0, br_pred_correct}, 32'h1);
    x_is_branch = 1'b0;

    // Saturation both ways
    for (int i = 0; i < 4; i++) run_branch(1'b1);
    chk("sat_hi", {30'b0, dut.u_bht.ctr_q[4]}, 32'h3);
    for (int i = 0; i < 4; i++) run_branch(1'b0);
    chk("sat_lo", {30'b0, dut.u_bht.ctr_q[4]}, 32'h0);
    chk("sat_mis", mispredict_count, 32'h4);

    // Stall during resolution
    x_is_branch = 1'b0; instruction = NOP; pc_select = 3'd1; jal_target = BR_PC;
    tick();
    instruction = BR40; pc_select = 3'd2;
    tick();
    instruction = NOP; x_is_branch = 1'b1; br_taken = 1'b1; alu_target = 32'h2050;
    pc_select = 3'd3; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_pc", pc, 32'h2014);
      chk("stl_xpc", x_pc, 32'h2010);
      chk("stl_ctr", {30'b0, dut.u_bht.ctr_q[4]}, 32'h0);
      chk("stl_mis", mispredict_count, 32'h4);
      chk("stl_corr", {31'b0, br_pred_correct}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("stl_pc_go", pc, 32'h2050);
    chk("stl_ctr_go", {30'b0, dut.u_bht.ctr_q[4]}, 32'h1);
    chk("stl_mis_go", mispredict_count, 32'h5);

    // jal then jalr
    x_is_branch = 1'b0; pc_select = 3'd1; jal_target = 32'h3000;
    tick();
    chk("jal_pc", pc, 32'h3000);
    chk("jal_xvalid", {31'b0, dut.x_valid}, 32'h1);
    pc_select = 3'd3; alu_target = 32'h4004;
    tick();
    chk("jalr_pc", pc, 32'h4004);
    chk("jalr_ctr4", {30'b0, dut.u_bht.ctr_q[4]}, 32'h1);
    chk("jalr_ctr0", {30'b0, dut.u_bht.ctr_q[0]}, 32'h1);
    pc_select = 3'd7;
    tick();
    chk("sel7_seq", pc, 32'h4008);

    // Reset mid-operation
    rst = 1'b1; stall = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    #1;
    chk("rst2_pc", pc, 32'h2000);
    chk("rst2_mis", mispredict_count, 32'h0);
    chk("rst2_ctr", {30'b0, dut.u_bht.ctr_q[4]}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
